// File: rtl/io_out_fifo.sv
// Output-port buffer: captures core output writes as {addr, data} entries in a
// first-word-fall-through FIFO drained over valid/ready, with a sticky drop flag.
module io_out_fifo #(
  parameter int NUBITS = 32,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 16,
  localparam int NBADDR = $clog2(NUIOOU),
  localparam int NBPTR  = $clog2(FDEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_en,
  input  logic [NBADDR-1:0] addr_out,
  input  logic [NUBITS-1:0] data_out,
  output logic              m_valid,
  output logic [NBADDR-1:0] m_addr,
  output logic [NUBITS-1:0] m_data,
  input  logic              m_ready,
  output logic [NBPTR:0]    count,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  input  logic              ovf_clr
);

  typedef struct packed {
    logic [NBADDR-1:0] addr;
    logic [NUBITS-1:0] data;
  } entry_t;

  entry_t           mem [FDEPTH];
  logic [NBPTR-1:0] wp;
  logic [NBPTR-1:0] rp;
  logic             push;
  logic             pop;
  logic             drop;

  // Status is derived from the registered count only, so no input reaches an output.
  assign full    = (count == (NBPTR+1)'(FDEPTH));
  assign empty   = (count == '0);
  assign m_valid = !empty;
  assign m_addr  = empty ? '0 : mem[rp].addr;
  assign m_data  = empty ? '0 : mem[rp].data;

  assign pop  = m_valid & m_ready;
  assign push = out_en & (!full | pop);
  assign drop = out_en & full & !pop;

  // NOTE: the storage array has no reset; only pointers and count define which
  // entries are live, so resetting the array would add muxes for no behaviour.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wp] <= '{addr: addr_out, data: data_out};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wp <= wp + NBPTR'(1);
      if (pop)  rp <= rp + NBPTR'(1);
      if (push && !pop)      count <= count + (NBPTR+1)'(1);
      else if (pop && !push) count <= count - (NBPTR+1)'(1);
      // Set wins over clear when a drop coincides with ovf_clr.
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_out_fifo.sv
// Self-checking bench for io_out_fifo: directed stimulus pushes expected entries
// into a scoreboard queue; a monitor pops and compares on every handshake.
module tb_io_out_fifo;
  localparam int NUBITS = 32;
  localparam int NUIOOU = 8;
  localparam int FDEPTH = 16;
  localparam int NBADDR = $clog2(NUIOOU);
  localparam int NBPTR  = $clog2(FDEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              out_en;
  logic [NBADDR-1:0] addr_out;
  logic [NUBITS-1:0] data_out;
  logic              m_valid;
  logic [NBADDR-1:0] m_addr;
  logic [NUBITS-1:0] m_data;
  logic              m_ready;
  logic [NBPTR:0]    count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              ovf_clr;

  logic [NBADDR+NUBITS-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  io_out_fifo #(.NUBITS(NUBITS), .NUIOOU(NUIOOU), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst), .out_en(out_en), .addr_out(addr_out),
    .data_out(data_out), .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
    .m_ready(m_ready), .count(count), .full(full), .empty(empty), .ovf(ovf),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int addr, input int data, input bit expect_stored);
    out_en   = 1'b1;
    addr_out = NBADDR'(addr);
    data_out = NUBITS'(data);
    if (expect_stored) exp_q.push_back({NBADDR'(addr), NUBITS'(data)});
    step();
    out_en = 1'b0;
  endtask

  task automatic drain_all(input string name);
    int budget = 64;
    m_ready = 1'b1;
    while (!empty && budget > 0) begin
      step();
      budget--;
    end
    m_ready = 1'b0;
    check({name, "_empty"}, 64'(empty), 64'd1);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid & ready hold now.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got addr=%0d data=0x%0h, expected no entry", m_addr, m_data);
        end else begin
          logic [NBADDR+NUBITS-1:0] e;
          e = exp_q.pop_front();
          if ({m_addr, m_data} !== e) begin
            n_fail++;
            $display("FAIL pop_entry: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                     m_addr, m_data, e[NBADDR+NUBITS-1:NUBITS], e[NUBITS-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; out_en = 1'b0; addr_out = '0; data_out = '0;
    m_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_count",   64'(count),   64'd0);
    check("rst_empty",   64'(empty),   64'd1);
    check("rst_full",    64'(full),    64'd0);
    check("rst_ovf",     64'(ovf),     64'd0);
    check("rst_m_data",  64'(m_data),  64'd0);
    check("rst_m_addr",  64'(m_addr),  64'd0);

    // Ready while empty must do nothing.
    m_ready = 1'b1; step(); m_ready = 1'b0;
    check("idle_ready_count", 64'(count), 64'd0);

    // Single write with one-cycle latency.
    write(3, 32'hDEADBEEF, 1'b1);
    check("single_valid", 64'(m_valid), 64'd1);
    check("single_addr",  64'(m_addr),  64'd3);
    check("single_data",  64'(m_data),  64'hDEADBEEF);
    check("single_count", 64'(count),   64'd1);
    m_ready = 1'b1; step(); m_ready = 1'b0;
    check("single_empty", 64'(empty), 64'd1);
    check("single_data0", 64'(m_data), 64'd0);

    // Fill, partial drain, refill across the pointer wrap, full drain.
    for (int i = 0; i < 16; i++) write(i % 8, i, 1'b1);
    check("fill_full",  64'(full),  64'd1);
    check("fill_count", 64'(count), 64'd16);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    m_ready = 1'b0;
    check("drain4_count", 64'(count), 64'd12);
    check("drain4_head",  64'(m_data), 64'd4);
    for (int i = 16; i < 20; i++) write(i % 8, i, 1'b1);
    check("refill_count", 64'(count), 64'd16);
    drain_all("wrap_drain");

    // Overflow: drop while full, clear, then drop coinciding with clear.
    for (int i = 0; i < 16; i++) write(i % 8, 32'h100 + i, 1'b1);
    write(1, 32'h55, 1'b0);
    check("ovf_count", 64'(count), 64'd16);
    check("ovf_set",   64'(ovf),   64'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_clr", 64'(ovf), 64'd0);
    ovf_clr = 1'b1;
    write(2, 32'h56, 1'b0);
    ovf_clr = 1'b0;
    check("ovf_set_wins", 64'(ovf),   64'd1);
    check("ovf_count2",   64'(count), 64'd16);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_clr2", 64'(ovf), 64'd0);

    // Simultaneous push and pop while full: accepted, no drop.
    m_ready = 1'b1;
    write(5, 32'hAA, 1'b1);
    m_ready = 1'b0;
    check("pp_count", 64'(count), 64'd16);
    check("pp_ovf",   64'(ovf),   64'd0);
    check("pp_head",  64'(m_data), 64'h101);
    drain_all("pp_drain");

    // Reset mid-stream discards contents and the reset-cycle write.
    for (int i = 0; i < 5; i++) write(i, 32'h200 + i, 1'b1);
    check("mid_count5", 64'(count), 64'd5);
    rst = 1'b1;
    write(6, 32'h77, 1'b0);
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_count", 64'(count),   64'd0);
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_data",  64'(m_data),  64'd0);
    step();
    check("mid_rst_nowrite", 64'(count), 64'd0);

    // Post-reset operation still correct.
    write(7, 32'hCAFE0001, 1'b1);
    check("post_rst_addr", 64'(m_addr), 64'd7);
    drain_all("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/io_out_fifo.md
# io_out_fifo

Output-port buffer placed directly downstream of the processor core's output interface. Captures every core output write (`out_en`, `addr_out`, `data_out`) as an {address, data} entry in a first-word-fall-through FIFO. Drains entries to external peripherals over a valid/ready handshake. Because the core cannot stall, it reports dropped writes through a sticky overflow flag.

## Interface

Parameters:
- `NUBITS`, 32, data word width; matches the core's `data_out`.
- `NUIOOU`, 8, number of output addresses; must be ≥ 2. Address width `NBADDR = $clog2(NUIOOU)`.
- `FDEPTH`, 16, FIFO depth in entries; power of two, ≥ 2. Pointer width `NBPTR = $clog2(FDEPTH)`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `out_en`  in  1  core output strobe; one write request per cycle high.
- `addr_out`  in  NBADDR  output port address from the core.
- `data_out`  in  NUBITS  output data from the core.
- `m_valid`  out  1  head entry available.
- `m_addr`  out  NBADDR  head entry address.
- `m_data`  out  NUBITS  head entry data.
- `m_ready`  in  1  consumer accepts the head entry.
- `count`  out  NBPTR+1  number of stored entries, 0..FDEPTH.
- `full`  out  1  `count == FDEPTH`.
- `empty`  out  1  `count == 0`.
- `ovf`  out  1  sticky overflow: a write was dropped.
- `ovf_clr`  in  1  clears `ovf`.

## Operation

- Storage: FDEPTH × (NBADDR+NUBITS) register array; write pointer `wp`, read pointer `rp`, and occupancy `count`.
- `pop = m_valid & m_ready`.
- `push = out_en & (!full | pop)`. Writing while full is legal only when a pop occurs in the same cycle.
- On push: store {addr_out, data_out} at `wp`; `wp <= wp+1` modulo FDEPTH.
- On pop: `rp <= rp+1` modulo FDEPTH.
- `count` changes by +1 on push only, −1 on pop only, and is unchanged on both or neither.
- Pointers wrap naturally at FDEPTH. Full and empty are distinguished by `count`, not by pointer equality.
- `m_valid = !empty`. `m_addr`/`m_data` show the entry at `rp` when not empty and are forced to 0 when empty.
- Ordering is strict FIFO. Address does not affect ordering or routing.
- Drop condition: `out_en & full & !pop`. The entry is discarded, FIFO contents are unchanged, and `ovf <= 1`.
- `ovf` holds until `ovf_clr`. If a drop and `ovf_clr` occur in the same cycle, set wins and `ovf` stays 1.
- There is no bypass. A push into an empty FIFO is not visible at `m_valid` until the following cycle.
- `m_ready` while empty has no effect.

## Timing

- Reset (sync, `rst` high at an edge): `wp = rp = 0`, `count = 0`, `ovf = 0`. Therefore `m_valid = 0`, `m_addr = 0`, `m_data = 0`, `empty = 1`, `full = 0`. Array contents are not reset.
- Reset asserted mid-operation discards all stored entries at that edge. `out_en` and `m_ready` in the reset cycle are ignored.
- Write latency: `out_en` sampled at edge N → entry visible at the head (if the FIFO was empty) and `m_valid = 1` during cycle N+1.
- Pop: head consumed at the edge where `m_valid & m_ready`. The next entry (or empty) appears in the following cycle.
- `count`, `full`, `empty`, `ovf` are registered or derived only from registered state. There is no combinational path from inputs to any output.
- Sustained throughput: one push and one pop per cycle with no bubbles while not empty.
- The core issues at most one write per cycle. Back-to-back `out_en` is supported.

## Test plan

- Reset/idle: hold `rst` 2 cycles, then release → `m_valid = 0`, `count = 0`, `empty = 1`, `ovf = 0`, `m_data = 0`.
- Single write: `out_en = 1`, `addr_out = 3`, `data_out = 0xDEADBEEF` for 1 cycle with `m_ready = 0` → next cycle `m_valid = 1`, `m_addr = 3`, `m_data = 0xDEADBEEF`, `count = 1`. Raising `m_ready` for 1 cycle → `empty = 1` on the following cycle.
- Fill and wrap: 16 writes with `data = 0..15`, `addr = i%8`, `m_ready = 0` → `full = 1`, `count = 16`. Drain 4, write 4 more (`16..19`), drain all → order 0..19, with pointers wrapped.
- Overflow: full FIFO, `out_en` with `data = 0x55`, `m_ready = 0` → entry dropped, `count` stays 16, `ovf = 1` next cycle. A later `ovf_clr` → `ovf = 0`. Drop and `ovf_clr` in the same cycle → `ovf = 1`.
- Simultaneous push/pop when full: `out_en` (`data = 0xAA`) and `m_ready` in the same cycle → no drop, `ovf` unchanged, `count` stays 16, 0xAA is last out.
- Reset mid-stream: 5 entries stored, assert `rst` for 1 cycle with `out_en = 1` → `count = 0`, `m_valid = 0`, and the reset-cycle write is not stored.
